dtc_vote_accum: RTL and testbench

//  Downstream stage of the combinational decision-tree classifier. Takes one 8-bit

---
 rtl/dtc_pkg.sv | 6 +
 rtl/dtc_bit_counter.sv | 25 ++
 rtl/dtc_vote_accum.sv | 107 ++++++++++
 tb/tb_dtc_vote_accum.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared decision-tree classifier constants and the vote accumulator state type.
package dtc_pkg;
    localparam int DTC_W = 8;

    typedef enum logic {ACCUM, HOLD} vote_st_t;
endpackage

// File: rtl/dtc_bit_counter.sv
// Per-bit ones counter for the vote window; exposes the post-increment value so the
// window-closing sample can be folded into the vote in the same cycle.
module dtc_bit_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_next
);
    logic [CNT_W-1:0] cnt;

    assign cnt_next = cnt + CNT_W'(inc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
endmodule

// File: rtl/dtc_vote_accum.sv
// Windowed per-bit strict-majority vote over classifier prediction words.
// Accumulates WINDOW accepted samples, then holds the registered vote until taken.
module dtc_vote_accum
    import dtc_pkg::*;
#(
    parameter  int W      = DTC_W,
    parameter  int WINDOW = 16,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_pred,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_vote,
    output logic [CNT_W-1:0] out_ones
);
    localparam logic [CNT_W-1:0] NS_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W+1:0] WIN_X   = (CNT_W + 2)'(WINDOW);

    vote_st_t         state;
    vote_st_t         state_next;
    logic [CNT_W-1:0] nsamp;
    logic [CNT_W-1:0] nxt [W];
    logic [W-1:0]     vote_next;
    logic             in_xfer;
    logic             out_xfer;
    logic             last;
    logic             cnt_clr;

    // Doubling keeps the strict-majority test exact for odd WINDOW; ties vote 0.
    function automatic logic majority(input logic [CNT_W-1:0] c);
        return {1'b0, c, 1'b0} > WIN_X;
    endfunction

    assign in_xfer  = in_valid && in_ready && !clear;
    assign out_xfer = out_valid && out_ready && !clear;
    assign last     = in_xfer && (nsamp == NS_LAST);
    assign cnt_clr  = clear || out_xfer;

    for (genvar i = 0; i < W; i++) begin : g_bit
        dtc_bit_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (cnt_clr),
            .inc      (in_xfer && in_pred[i]),
            .cnt_next (nxt[i])
        );
    end

    always_comb begin
        vote_next = '0;
        for (int i = 0; i < W; i++) begin
            vote_next[i] = majority(nxt[i]);
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
        if (clear) state_next = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nsamp <= '0;
        end else if (cnt_clr) begin
            nsamp <= '0;
        end else if (in_xfer) begin
            nsamp <= nsamp + CNT_W'(1);
        end
    end

    // Vote registers update only on the window-closing transfer; clear leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vote <= '0;
            out_ones <= '0;
        end else if (last) begin
            out_vote <= vote_next;
            out_ones <= nxt[0];
        end
    end
endmodule

// File: tb/tb_dtc_vote_accum.sv
// Directed and randomized-gap checks of the windowed majority vote accumulator.
module tb_dtc_vote_accum;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pred;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_vote;
    logic [4:0] out_ones;

    int total = 0;
    int bad   = 0;

    dtc_vote_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pred   (in_pred),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vote  (out_vote),
        .out_ones  (out_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and wait (bounded) until it transfers.
    task automatic push(input logic [7:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pred  = v;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("push_timeout", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("take_valid_low", 32'(out_valid), 32'(0));
        chk("take_ready_high", 32'(in_ready), 32'(1));
    endtask

    // Sample k is a for k<na, else b; with alt set samples alternate a,b,a,b...
    task automatic run_window(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input int na, input bit alt,
                              input logic [7:0] exp_vote, input logic [4:0] exp_ones);
        logic [7:0] v;
        for (int k = 0; k < 16; k++) begin
            if (alt) v = (k % 2 == 0) ? a : b;
            else     v = (k < na) ? a : b;
            push(v);
            if (k < 15) chk({tag, "_early_valid"}, 32'(out_valid), 32'(0));
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'(1));
        chk({tag, "_vote"}, 32'(out_vote), 32'(exp_vote));
        chk({tag, "_ones"}, 32'(out_ones), 32'(exp_ones));
    endtask

    initial begin
        int cnt [8];
        logic [7:0] pred;
        logic [7:0] mvote;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_pred = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_vote", 32'(out_vote), 32'(0));
        chk("rst_ones", 32'(out_ones), 32'(0));

        run_window("all_ff", 8'hFF, 8'hFF, 16, 1'b0, 8'hFF, 5'd16);
        chk("all_ff_ready_low", 32'(in_ready), 32'(0));
        take();

        run_window("tie", 8'h0F, 8'hF0, 0, 1'b1, 8'h00, 5'd8);
        take();

        run_window("nine_one", 8'h01, 8'h00, 9, 1'b0, 8'h01, 5'd9);
        take();
        run_window("seven_one", 8'h01, 8'h00, 7, 1'b0, 8'h00, 5'd7);
        take();

        // Backpressure: reach HOLD and stall with input offered.
        run_window("bp", 8'h3C, 8'h3C, 16, 1'b0, 8'h3C, 5'd0);
        in_valid = 1'b1;
        in_pred  = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_ready", 32'(in_ready), 32'(0));
            chk("bp_vote", 32'(out_vote), 32'(8'h3C));
            chk("bp_valid", 32'(out_valid), 32'(1));
        end
        in_valid = 1'b0;
        take();
        run_window("after_bp", 8'hA5, 8'hA5, 16, 1'b0, 8'hA5, 5'd16);
        take();

        // Clear mid-window drops the offered sample and the partial window.
        for (int k = 0; k < 5; k++) push(8'hFF);
        clear = 1'b1; in_valid = 1'b1; in_pred = 8'hFF;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'(0));
        chk("clr_ready", 32'(in_ready), 32'(1));
        chk("clr_vote_kept", 32'(out_vote), 32'(8'hA5));
        chk("clr_ones_kept", 32'(out_ones), 32'(16));
        run_window("post_clr", 8'h00, 8'h00, 16, 1'b0, 8'h00, 5'd0);
        take();

        // Reset while holding a result.
        run_window("pre_rst", 8'hFF, 8'hFF, 16, 1'b0, 8'hFF, 5'd16);
        rst_n = 1'b0;
        tick();
        chk("hrst_valid", 32'(out_valid), 32'(0));
        chk("hrst_vote", 32'(out_vote), 32'(0));
        chk("hrst_ones", 32'(out_ones), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("hrst_ready", 32'(in_ready), 32'(1));
        run_window("post_rst", 8'h81, 8'h00, 9, 1'b0, 8'h81, 5'd9);
        take();

        // Random gaps and consumer delays against a reference vote model.
        for (int w = 0; w < 1000; w++) begin
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            for (int k = 0; k < 16; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                pred = 8'($urandom);
                for (int i = 0; i < 8; i++) cnt[i] += int'(pred[i]);
                push(pred);
            end
            mvote = '0;
            for (int i = 0; i < 8; i++) mvote[i] = (2 * cnt[i] > 16);
            chk("rnd_valid", 32'(out_valid), 32'(1));
            chk("rnd_vote", 32'(out_vote), 32'(mvote));
            chk("rnd_ones", 32'(out_ones), 32'(cnt[0]));
            begin
                int d;
                d = $urandom_range(0, 3);
                for (int g = 0; g < d; g++) tick();
            end
            take();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
